light_mode_fsm: RTL and testbench

- Downstream consumer of the debounced button controller's single-cycle release pulse.
- Each pulse steps the light stand through five brightness modes: OFF -> LOW -> MID -> HIGH -> FULL -> OFF.
- Each mode drives the lamp output with a glitch-free PWM duty cycle.
- Also exports the current mode for status LEDs.

---
 rtl/light_pkg.sv | 35 +++
 rtl/pwm_gen.sv | 52 +++++
 rtl/light_mode_fsm.sv | 88 ++++++++
 tb/tb_light_mode_fsm.sv | 246 ++++++++++++++++++++++++
 4 files changed

// File: rtl/light_pkg.sv
// Shared mode encodings and helpers for the light stand mode controller.
// Modes step OFF -> LOW -> MID -> HIGH -> FULL -> OFF.
package light_pkg;

  typedef enum logic [2:0] {
    MODE_OFF  = 3'd0,
    MODE_LOW  = 3'd1,
    MODE_MID  = 3'd2,
    MODE_HIGH = 3'd3,
    MODE_FULL = 3'd4
  } mode_e;

  localparam mode_e MODE_LAST = MODE_FULL;

  // Duty target in PWM clocks; period is a multiple of 4, so quarters are exact.
  function automatic int unsigned duty_target(mode_e mode, int unsigned period);
    int unsigned duty;
    case (mode)
      MODE_LOW:  duty = period / 4;
      MODE_MID:  duty = period / 2;
      MODE_HIGH: duty = 3 * (period / 4);
      MODE_FULL: duty = period;
      default:   duty = 0;
    endcase
    return duty;
  endfunction

  function automatic mode_e next_mode(mode_e mode);
    mode_e nxt;
    if (mode == MODE_LAST) nxt = MODE_OFF;
    else                   nxt = mode_e'(mode + 3'd1);
    return nxt;
  endfunction

endpackage

// File: rtl/pwm_gen.sv
// Glitch-free PWM generator: free-running counter, duty shadow register loaded
// at period end, registered lamp output and period-start strobe.
module pwm_gen #(
  parameter int unsigned PWM_PERIOD = 100_000,
  localparam int unsigned CW = $clog2(PWM_PERIOD),
  localparam int unsigned DW = CW + 1
) (
  input  logic          i_clk,
  input  logic          i_reset,
  input  logic [DW-1:0] i_duty,
  input  logic          i_force_off,
  output logic          o_light,
  output logic          o_period_start
);

  localparam logic [CW-1:0] CNT_LAST = CW'(PWM_PERIOD - 1);

  logic [CW-1:0] cnt_q, cnt_d;
  logic [DW-1:0] duty_q, duty_d;
  logic          light_q, light_d;
  logic          period_start_q, period_start_d;

  always_comb begin
    cnt_d = (cnt_q == CNT_LAST) ? '0 : cnt_q + CW'(1);

    duty_d = duty_q;
    if (cnt_q == CNT_LAST) duty_d = i_duty;
    // Forced off clears the shadow too, so a later mode only takes effect at a period boundary.
    if (i_force_off) duty_d = '0;

    light_d        = !i_force_off && ({1'b0, cnt_q} < duty_q);
    period_start_d = (cnt_q == '0);
  end

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      cnt_q          <= '0;
      duty_q         <= '0;
      light_q        <= 1'b0;
      period_start_q <= 1'b0;
    end else begin
      cnt_q          <= cnt_d;
      duty_q         <= duty_d;
      light_q        <= light_d;
      period_start_q <= period_start_d;
    end
  end

  assign o_light        = light_q;
  assign o_period_start = period_start_q;

endmodule

// File: rtl/light_mode_fsm.sv
// Light stand mode controller: steps brightness mode on each button pulse and
// drives the lamp PWM. Define LIGHT_AUTO_OFF_EN to add the idle auto-off timer.
module light_mode_fsm #(
  parameter int unsigned PWM_PERIOD      = 100_000,
  parameter int unsigned AUTO_OFF_CYCLES = 1_500_000_000
) (
  input  logic       i_clk,
  input  logic       i_reset,
  input  logic       i_button,
  output logic [2:0] o_mode,
  output logic       o_light,
  output logic       o_period_start
);

  import light_pkg::*;

  localparam int unsigned DW = $clog2(PWM_PERIOD) + 1;

  mode_e         mode_q, mode_d;
  logic [DW-1:0] duty_tgt;
  logic          force_off;

`ifdef LIGHT_AUTO_OFF_EN
  localparam int unsigned IW = (AUTO_OFF_CYCLES > 1) ? $clog2(AUTO_OFF_CYCLES) : 1;
  localparam logic [IW-1:0] IDLE_LAST = IW'(AUTO_OFF_CYCLES - 1);

  logic [IW-1:0] idle_q, idle_d;

  // A pulse coinciding with the timeout wins; the timer only runs outside OFF.
  always_comb begin
    mode_d = mode_q;
    idle_d = idle_q;
    if (i_button) begin
      mode_d = next_mode(mode_q);
      idle_d = '0;
    end else if (mode_q != MODE_OFF) begin
      if (idle_q == IDLE_LAST) begin
        mode_d = MODE_OFF;
        idle_d = '0;
      end else begin
        idle_d = idle_q + IW'(1);
      end
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      mode_q <= MODE_OFF;
      idle_q <= '0;
    end else begin
      mode_q <= mode_d;
      idle_q <= idle_d;
    end
  end
`else
  logic unused_auto_off;
  assign unused_auto_off = ^AUTO_OFF_CYCLES;

  always_comb begin
    mode_d = mode_q;
    if (i_button) mode_d = next_mode(mode_q);
  end

  always_ff @(posedge i_clk) begin
    if (i_reset) mode_q <= MODE_OFF;
    else         mode_q <= mode_d;
  end
`endif

  always_comb begin
    duty_tgt  = DW'(duty_target(mode_q, PWM_PERIOD));
    force_off = (mode_q == MODE_OFF);
  end

  pwm_gen #(
    .PWM_PERIOD(PWM_PERIOD)
  ) u_pwm (
    .i_clk          (i_clk),
    .i_reset        (i_reset),
    .i_duty         (duty_tgt),
    .i_force_off    (force_off),
    .o_light        (o_light),
    .o_period_start (o_period_start)
  );

  assign o_mode = mode_q;

endmodule

// File: tb/tb_light_mode_fsm.sv
// Self-checking bench for light_mode_fsm with PWM_PERIOD=8, AUTO_OFF_CYCLES=20.
// Honours LIGHT_AUTO_OFF_EN to select which auto-off behaviour is expected.
module tb_light_mode_fsm;

  localparam int P    = 8;
  localparam int AUTO = 20;

  logic       clk = 1'b0;
  logic       rst;
  logic       btn;
  logic [2:0] o_mode;
  logic       o_light;
  logic       o_period_start;

  int checks   = 0;
  int failures = 0;

  light_mode_fsm #(
    .PWM_PERIOD      (P),
    .AUTO_OFF_CYCLES (AUTO)
  ) dut (
    .i_clk          (clk),
    .i_reset        (rst),
    .i_button       (btn),
    .o_mode         (o_mode),
    .o_light        (o_light),
    .o_period_start (o_period_start)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s actual=%0d expected=%0d at %0t", name, act, exp, $time);
    end
  endtask

  // Model: mode as an integer 0..4, period phase, and the duty (in clocks)
  // that the current period was granted when it began.
  int m_mode = 0, m_ph = 0, m_pd = 0, m_light = 0, m_ps = 0, m_idle = 0;
  bit m_valid = 1'b0;

  always @(posedge clk) begin
    if (rst) begin
      m_mode = 0; m_ph = 0; m_pd = 0; m_light = 0; m_ps = 0; m_idle = 0;
      m_valid = 1'b1;
    end else begin
      m_light = (m_mode != 0 && m_ph < m_pd) ? 1 : 0;
      m_ps    = (m_ph == 0) ? 1 : 0;
      if (m_mode == 0)       m_pd = 0;
      else if (m_ph == P - 1) m_pd = m_mode * P / 4;
      m_ph = (m_ph + 1) % P;
      if (btn) begin
        m_mode = (m_mode + 1) % 5;
        m_idle = 0;
      end
`ifdef LIGHT_AUTO_OFF_EN
      else if (m_mode != 0) begin
        if (m_idle == AUTO - 1) begin
          m_mode = 0;
          m_idle = 0;
        end else begin
          m_idle++;
        end
      end
`endif
    end
  end

  always @(negedge clk) begin
    if (m_valid) begin
      chk("model_mode",  int'(o_mode),         m_mode);
      chk("model_light", int'(o_light),        m_light);
      chk("model_pstart", int'(o_period_start), m_ps);
    end
  end

  task automatic wait_phase(input int p);
    bit hit = 1'b0;
    for (int i = 0; i < 2 * P; i++) begin
      if (m_ph == p) begin
        hit = 1'b1;
        break;
      end
      @(negedge clk);
    end
    if (!hit) chk("wait_phase_timeout", 0, 1);
  endtask

  task automatic count8(output int hi);
    hi = 0;
    for (int i = 0; i < P; i++) begin
      hi += int'(o_light);
      @(negedge clk);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog actual=timeout required=finish");
    failures++;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $fatal(1, "watchdog");
  end

  int exp_mode [5] = '{1, 2, 3, 4, 0};
  int exp_hi   [5] = '{2, 4, 6, 8, 0};

  initial begin
    int hi, ps_cnt, nz_cnt;
    rst = 1'b1;
    btn = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_mode",   int'(o_mode),         0);
    chk("rst_light",  int'(o_light),        0);
    chk("rst_pstart", int'(o_period_start), 0);
    rst = 1'b0;

    // Idle after reset.
    ps_cnt = 0; hi = 0; nz_cnt = 0;
    for (int i = 0; i < 32; i++) begin
      @(negedge clk);
      ps_cnt += int'(o_period_start);
      hi     += int'(o_light);
      nz_cnt += (o_mode != 3'd0) ? 1 : 0;
    end
    chk("idle_pstarts", ps_cnt, 4);
    chk("idle_light",   hi,     0);
    chk("idle_mode",    nz_cnt, 0);

    // Full mode cycle, pulse sampled at counter=2, measure the next whole period.
    for (int k = 0; k < 5; k++) begin
      wait_phase(2);
      btn = 1'b1;
      @(negedge clk);
      btn = 1'b0;
      chk("step_mode", int'(o_mode), exp_mode[k]);
      wait_phase(1);
      chk("step_pstart", int'(o_period_start), 1);
      count8(hi);
      chk("step_high", hi, exp_hi[k]);
    end

    // Mode change mid-period must not disturb the running period.
    wait_phase(2);
    btn = 1'b1;
    @(negedge clk);
    btn = 1'b0;
    wait_phase(1);
    hi = 0;
    for (int i = 0; i < P; i++) begin
      hi += int'(o_light);
      btn = (i == 2);
      @(negedge clk);
    end
    btn = 1'b0;
    chk("mid_cur_high", hi, 2);
    chk("mid_mode", int'(o_mode), 2);
    count8(hi);
    chk("mid_next_high", hi, 4);

    // Held button: one step per sampled cycle, MID -> HIGH -> FULL.
    btn = 1'b1;
    @(negedge clk);
    chk("hold_mode1", int'(o_mode), 3);
    @(negedge clk);
    btn = 1'b0;
    chk("hold_mode2", int'(o_mode), 4);
    wait_phase(1);
    count8(hi);
    chk("full_high", hi, 8);

    // FULL -> OFF at counter=2 cuts the lamp immediately.
    wait_phase(2);
    btn = 1'b1;
    @(negedge clk);
    btn = 1'b0;
    chk("off_mode",   int'(o_mode),  0);
    chk("off_light1", int'(o_light), 1);
    @(negedge clk);
    chk("off_light2", int'(o_light), 0);
    count8(hi);
    chk("off_high", hi, 0);

    // Held three cycles from OFF reaches HIGH; then reset at counter=5.
    wait_phase(2);
    btn = 1'b1;
    repeat (3) @(negedge clk);
    btn = 1'b0;
    chk("hold3_mode", int'(o_mode), 3);
    wait_phase(1);
    count8(hi);
    chk("high_high", hi, 6);
    wait_phase(5);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("mrst_mode",   int'(o_mode),         0);
    chk("mrst_light",  int'(o_light),        0);
    chk("mrst_pstart", int'(o_period_start), 0);
    @(negedge clk);
    chk("mrst_cnt0_pstart", int'(o_period_start), 1);
    chk("mrst_light2",      int'(o_light),        0);

    // Enter LOW and watch the idle behaviour.
    btn = 1'b1;
    @(negedge clk);
    btn = 1'b0;
    chk("ao_enter_low", int'(o_mode), 1);
`ifdef LIGHT_AUTO_OFF_EN
    repeat (19) @(negedge clk);
    chk("ao_low_19", int'(o_mode), 1);
    @(negedge clk);
    chk("ao_off_20", int'(o_mode), 0);
    btn = 1'b1;
    @(negedge clk);
    btn = 1'b0;
    chk("ao_reenter_low", int'(o_mode), 1);
    repeat (19) @(negedge clk);
    chk("ao_low_19b", int'(o_mode), 1);
    btn = 1'b1;
    @(negedge clk);
    btn = 1'b0;
    chk("ao_pulse_wins", int'(o_mode), 2);
    repeat (19) @(negedge clk);
    chk("ao_mid_19", int'(o_mode), 2);
    @(negedge clk);
    chk("ao_mid_off", int'(o_mode), 0);
`else
    nz_cnt = 0;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      nz_cnt += (o_mode == 3'd1) ? 1 : 0;
    end
    chk("persist_low", nz_cnt, 100);
`endif

    repeat (4) @(negedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
